// File: rtl/cpu_types_pkg.sv
// Shared datapath types: machine word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/memory_arbiter_pkg.sv
// Arbiter state encoding and default instruction-starvation bound.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam logic [3:0] STARVE_LIMIT_DEFAULT = 4'd4;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the arbiter's requester and RAM signals; arb = block side, tb = bench side.
interface memory_arbiter_if (
  input logic CLK,
  input logic nRST
);
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport arb (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    input  CLK, nRST, iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
  );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access, data first.
// Optional FAIR_ARB_EN bounds how many data grants may starve a pending fetch.
module memory_arbiter
  import cpu_types_pkg::*;
  import memory_arbiter_pkg::*;
`ifdef FAIR_ARB_EN
#(
  parameter logic [3:0] STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)
`endif
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  arb_state_t state, next_state, arb_pick;
  ramstate_t  rs;
  logic       dreq;
  logic       i_done;
  logic       d_done;
  logic       starved;

  assign rs     = ramstate_t'(ramstate);
  assign dreq   = dREN | dWEN;
  assign i_done = (state == IGNT) && (rs == ACCESS) && iREN;
  assign d_done = (state == DGNT) && (rs == ACCESS) && dreq;

`ifdef FAIR_ARB_EN
  logic [3:0] starve_cnt, starve_cnt_next;

  // Arbitration looks at the post-update count so the limit-th data grant hands over at once.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!iREN || i_done) begin
      starve_cnt_next = '0;
    end else if (d_done && (starve_cnt != '1)) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end
  end

  assign starved = iREN && (starve_cnt_next == STARVE_LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end
`else
  assign starved = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    arb_pick = IDLE;
    if (starved) begin
      arb_pick = IGNT;
    end else if (dreq) begin
      arb_pick = DGNT;
    end else if (iREN) begin
      arb_pick = IGNT;
    end
  end

  // A dropped request abandons the grant; only a completion re-arbitrates in the same edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = arb_pick;
      IGNT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else if (i_done) begin
          next_state = arb_pick;
        end
      end
      DGNT: begin
        if (!dreq) begin
          next_state = IDLE;
        end else if (d_done) begin
          next_state = arb_pick;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    case (state)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
      end
      default: ;
    endcase
  end

  assign iwait = iREN & ~i_done;
  assign dwait = dreq & ~d_done;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter; expectations follow FAIR_ARB_EN when defined.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic clk;
  logic nrst;

  memory_arbiter_if bus (.CLK(clk), .nRST(nrst));

  memory_arbiter dut (
    .CLK      (clk),
    .nRST     (nrst),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .dREN     (bus.dREN),
    .dWEN     (bus.dWEN),
    .daddr    (bus.daddr),
    .dstore   (bus.dstore),
    .iwait    (bus.iwait),
    .dwait    (bus.dwait),
    .iload    (bus.iload),
    .dload    (bus.dload),
    .ramREN   (bus.ramREN),
    .ramWEN   (bus.ramWEN),
    .ramaddr  (bus.ramaddr),
    .ramstore (bus.ramstore),
    .ramload  (bus.ramload),
    .ramstate (bus.ramstate)
  );

  typedef struct {
    bit          side;   // 0 = instruction, 1 = data
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input bit side, input logic [31:0] addr, input logic ren,
                      input logic wen, input logic [31:0] store, input logic [31:0] load);
    exp_t e;
    e.side = side; e.addr = addr; e.ren = ren; e.wen = wen; e.store = store; e.load = load;
    exp_q.push_back(e);
  endtask

  task automatic score(input bit side, input logic [31:0] load);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_completion", {31'd0, side}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("grant_side", {31'd0, side}, {31'd0, e.side});
      check("ramaddr",    bus.ramaddr,   e.addr);
      check("ramREN",     {31'd0, bus.ramREN}, {31'd0, e.ren});
      check("ramWEN",     {31'd0, bus.ramWEN}, {31'd0, e.wen});
      check("ramstore",   bus.ramstore,  e.store);
      check("load",       load,          e.load);
    end
  endtask

  // Monitor: a completion is a held request whose wait has dropped.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (bus.iREN && !bus.iwait) score(1'b0, bus.iload);
      if ((bus.dREN || bus.dWEN) && !bus.dwait) score(1'b1, bus.dload);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    tick(); tick();
    @(negedge clk);
    check("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_iwait", {31'd0, bus.iwait}, 32'd0);
    check("rst_dwait", {31'd0, bus.dwait}, 32'd0);
    tick(); nrst = 1'b1;
    tick();

    // Instruction-only read, two BUSY cycles then ACCESS.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040; bus.ramstate = BUSY;
    push(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'd0, 32'h2108_0004);
    @(negedge clk);
    check("i_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check("i_idle_iwait",  {31'd0, bus.iwait},  32'd1);
    tick();
    @(negedge clk);
    check("i_gnt_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    check("i_gnt_ramaddr", bus.ramaddr, 32'h0000_0040);
    check("i_busy_iwait",  {31'd0, bus.iwait},  32'd1);
    check("i_busy_dload",  bus.dload, 32'd0);
    tick();
    @(negedge clk);
    check("i_busy2_iwait", {31'd0, bus.iwait}, 32'd1);
    tick();
    bus.ramstate = ACCESS; bus.ramload = 32'h2108_0004;
    tick();
    bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = '0;
    @(negedge clk);
    check("i_drop_ramREN", {31'd0, bus.ramREN}, 32'd0);
    tick();
    @(negedge clk);
    check("i_idle_after", {31'd0, bus.iwait}, 32'd0);

    // Contention: data wins, fetch waits until its own grant completes.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0044;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_8000; bus.ramstate = BUSY;
    push(1'b1, 32'h0000_8000, 1'b1, 1'b0, 32'd0, 32'h1111_1111);
    push(1'b0, 32'h0000_0044, 1'b1, 1'b0, 32'd0, 32'h2222_2222);
    tick();
    @(negedge clk);
    check("c_dgnt_ramaddr", bus.ramaddr, 32'h0000_8000);
    check("c_dgnt_iwait", {31'd0, bus.iwait}, 32'd1);
    tick();
    bus.ramstate = ACCESS; bus.ramload = 32'h1111_1111;
    @(negedge clk);
    check("c_dacc_iwait", {31'd0, bus.iwait}, 32'd1);
    tick();
    bus.dREN = 1'b0; bus.ramstate = BUSY; bus.ramload = '0;
    @(negedge clk);
    check("c_ddrop_iwait", {31'd0, bus.iwait}, 32'd1);
    tick();
    @(negedge clk);
    check("c_idle_iwait", {31'd0, bus.iwait}, 32'd1);
    tick();
    @(negedge clk);
    check("c_igrant_ramaddr", bus.ramaddr, 32'h0000_0044);
    check("c_ibusy_iwait", {31'd0, bus.iwait}, 32'd1);
    tick();
    bus.ramstate = ACCESS; bus.ramload = 32'h2222_2222;
    tick();
    bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = '0;
    tick();

    // Write with both strobes requested: the write wins.
    tick();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h0000_0100;
    bus.dstore = 32'hDEAD_BEEF; bus.ramstate = BUSY; bus.ramload = 32'h0BAD_0BAD;
    push(1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_0BAD);
    @(negedge clk);
    check("w_idle_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    tick();
    @(negedge clk);
    check("w_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
    check("w_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    check("w_ramstore", bus.ramstore, 32'hDEAD_BEEF);
    check("w_dwait",    {31'd0, bus.dwait},  32'd1);
    tick();
    bus.ramstate = ACCESS;
    tick();
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE; bus.ramload = '0;
    @(negedge clk);
    check("w_drop_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    tick();

    // ERROR during a fetch grant is a retry.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0080; bus.ramstate = BUSY;
    push(1'b0, 32'h0000_0080, 1'b1, 1'b0, 32'd0, 32'h3333_3333);
    tick();
    bus.ramstate = ERROR;
    @(negedge clk);
    check("e_iwait",   {31'd0, bus.iwait},  32'd1);
    check("e_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    check("e_ramaddr", bus.ramaddr, 32'h0000_0080);
    tick();
    bus.ramstate = ACCESS; bus.ramload = 32'h3333_3333;
    tick();
    bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = '0;
    tick();

    // Asynchronous reset in the middle of a busy data grant.
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0200; bus.ramstate = BUSY;
    tick();
    @(negedge clk);
    check("r_dgnt_ramREN", {31'd0, bus.ramREN}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("r_async_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check("r_async_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    tick();
    bus.dREN = 1'b0; bus.ramstate = FREE; nrst = 1'b1;
    @(negedge clk);
    check("r_rel_iwait",  {31'd0, bus.iwait},  32'd0);
    check("r_rel_dwait",  {31'd0, bus.dwait},  32'd0);
    check("r_rel_ramREN", {31'd0, bus.ramREN}, 32'd0);
    tick();

    // Both requesters held, RAM always ready: grant order depends on fair mode.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0400;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0500; bus.dstore = 32'h1234_5678;
    bus.ramstate = ACCESS; bus.ramload = 32'h5A5A_0000;
    for (int unsigned k = 1; k <= 12; k++) begin
`ifdef FAIR_ARB_EN
      if (k % 5 == 0) push(1'b0, 32'h0000_0400, 1'b1, 1'b0, 32'd0, 32'h5A5A_0000);
      else            push(1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h1234_5678, 32'h5A5A_0000);
`else
      push(1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h1234_5678, 32'h5A5A_0000);
`endif
    end
    repeat (12) tick();
    tick();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE; bus.ramload = '0;
    tick(); tick();
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
